dtcm_port_arbiter: RTL and testbench
====================================

# dtcm_port_arbiter

Shares the single-port DTCM SRAM between the core load/store unit and the AXI4-lite TCM decoder's DTCM path. Core requests have fixed priority. A consecutive-loss counter guarantees AXI forward progress. Read data is routed back to the requester that owned the access. The block sits between the core pipeline, the TCM decoder and the DTCM macro.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width of both requesters.
- `DEPTH`, 4096, DTCM depth in 32-bit words; `MEM_AW` = clog2(`DEPTH`).
- `BASE`, `` `DTCM_START_ADDR ``, byte address of DTCM word 0.
- `STARVE_LIMIT`, 4, consecutive lost cycles after which a pending AXI request wins (1..15).

Ports:
- `ACLK`  in  1  clock; single clock domain.
- `ARESET`  in  1  synchronous, active-high reset.
- `cpu_req`  in  1  core access request; held until granted.
- `cpu_rd0_wr1`  in  1  0 = read, 1 = write.
- `cpu_addr`  in  `ADDR_W`  byte address.
- `cpu_byte_strobe`  in  4  write byte enables.
- `cpu_write_data`  in  32  write data.
- `cpu_gnt`  out  1  access accepted this cycle.
- `cpu_read_data`  out  32  read data.
- `cpu_read_data_valid`  out  1  read data valid.
- `AXI_dtcm_access`, `AXI_tcm_rd0_wr1`, `AXI_tcm_addr`, `AXI_tcm_byte_strobe`, `AXI_tcm_write_data`  in  1/1/`ADDR_W`/4/32  decoder-side request, same semantics as the core side.
- `AXI_dtcm_gnt`  out  1  AXI access accepted.
- `AXI_dtcm_read_data`  out  32  read data.
- `AXI_dtcm_read_data_valid`  out  1  read data valid.
- `mem_en`, `mem_we`  out  1  SRAM enable and write enable.
- `mem_addr`  out  `MEM_AW`  word address.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  SRAM write data.
- `mem_rdata`  in  32  SRAM read data, valid one cycle after a read enable.

## Operation
- Grant is combinational from the current requests and the starve counter. At most one grant per cycle; a grant can issue every cycle.
- Arbitration:
  - Only one requester active → that requester is granted.
  - Both active and `starve_cnt` < `STARVE_LIMIT` → core wins and `starve_cnt` increments.
  - Both active and `starve_cnt` == `STARVE_LIMIT` → AXI wins and `starve_cnt` clears.
- `starve_cnt` also clears on any AXI grant and whenever `AXI_dtcm_access` is low. It never exceeds `STARVE_LIMIT`.
- SRAM drive from the granted requester:
  - `mem_en` = any grant; `mem_we` = granted `rd0_wr1`.
  - `mem_addr` = (addr − `BASE`) >> 2, truncated to `MEM_AW`.
  - `mem_be` = strobe on writes, 4'hF on reads; `mem_wdata` = granted write data.
- Return path:
  - Registered `rd_owner` (none/cpu/axi) is set on a read grant and cleared otherwise.
  - The following cycle, the owner's `*_read_data_valid` = 1 and its `*_read_data` = `mem_rdata`. The non-owner's data output reads 0.
- Writes complete at grant; no read-valid is produced for a write.
- Requests are ignored during `ARESET`.

## Timing
- Reset values: all grants, valids, `mem_en`, `mem_we` = 0; all data/address outputs = 0; `starve_cnt` = 0; `rd_owner` = none.
- Grant latency: 0 cycles (same cycle as request when uncontended). Read latency: grant cycle + 1.
- Back-to-back reads from alternating owners each return in order, one per cycle, to the correct owner.
- Reset asserted in the cycle after a read grant → no read-valid is produced; `rd_owner` is cleared.
- A requester dropping `req` without a grant is legal. No state is kept apart from the AXI `starve_cnt` clear.
- Address outside [`BASE`, `BASE` + 4·`DEPTH`) is not checked; the decoder filters range.

## Structure
- `DTCM_START_ADDR`, `DTCM_SIZE` and the default `DTCM_ARB_STARVE_LIMIT` live in `top_defines.vh`.
- Owner encoding (2-bit: none/cpu/axi) is a shared define.
- One sub-module, `tcm_arb_starve_cnt`: saturating counter with inc/clr/limit-reached.
- The remainder is a flat grant mux plus the return-path register.

## Test plan
- Core read 0x0 alone with `mem_rdata` = 0xDEADBEEF → `cpu_gnt` same cycle; `cpu_read_data_valid` next cycle with 0xDEADBEEF; AXI outputs stay 0.
- AXI write at `BASE`+0x10, strobe 4'b0011, data 0x1234 → `AXI_dtcm_gnt`; `mem_we` = 1, `mem_addr` = 4, `mem_be` = 4'b0011; no read-valid follows.
- Core and AXI both requesting continuously with `STARVE_LIMIT` = 4 → core granted 4 cycles, AXI granted in the 5th, pattern repeats.
- Core read then AXI read on consecutive cycles → valids on cycles 2 and 3, each to its own owner with the respective `mem_rdata`.
- `ARESET` pulsed the cycle after an AXI read grant → `AXI_dtcm_read_data_valid` stays 0; all outputs return to reset values.
- AXI request dropped after 3 lost cycles, then reasserted → `starve_cnt` restarts from 0; AXI waits 4 more contended cycles before winning.

Source files
------------

// File: rtl/dtcm_port_arbiter_pkg.sv
// Shared definitions for the DTCM port arbiter.
// Memory map defaults, owner encoding and counter width.
package dtcm_port_arbiter_pkg;

   localparam logic [31:0] DTCM_START_ADDR       = 32'h2000_0000;
   localparam int          DTCM_SIZE             = 16384;
   localparam int          DTCM_ARB_STARVE_LIMIT = 4;
   localparam int          STARVE_W              = 4;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_AXI  = 2'd2
   } owner_e;

endpackage

// File: rtl/tcm_arb_starve_cnt.sv
// Saturating consecutive-loss counter for the AXI requester.
// Clear has priority over increment; counting stops at the limit.
module tcm_arb_starve_cnt
   import dtcm_port_arbiter_pkg::*;
#(
   parameter int LIMIT = DTCM_ARB_STARVE_LIMIT
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_inc,
   input  logic                i_clr,
   output logic                o_limit,
   output logic [STARVE_W-1:0] o_cnt
);

   localparam logic [STARVE_W-1:0] LIM = STARVE_W'(LIMIT);

   logic [STARVE_W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != LIM)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_limit = (r_cnt == LIM);
   assign o_cnt   = r_cnt;

endmodule

// File: rtl/dtcm_port_arbiter.sv
// Shares the single-port DTCM between the core LSU and the AXI TCM path.
// Core has fixed priority; the starve counter forces an AXI win.
module dtcm_port_arbiter
   import dtcm_port_arbiter_pkg::*;
#(
   parameter int              ADDR_W       = 32,
   parameter int              DEPTH        = 4096,
   parameter int              MEM_AW       = $clog2(DEPTH),
   parameter logic [ADDR_W-1:0] BASE       = ADDR_W'(DTCM_START_ADDR),
   parameter int              STARVE_LIMIT = DTCM_ARB_STARVE_LIMIT
) (
   input  logic              ACLK,
   input  logic              ARESET,
   input  logic              cpu_req,
   input  logic              cpu_rd0_wr1,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [3:0]        cpu_byte_strobe,
   input  logic [31:0]       cpu_write_data,
   output logic              cpu_gnt,
   output logic [31:0]       cpu_read_data,
   output logic              cpu_read_data_valid,
   input  logic              AXI_dtcm_access,
   input  logic              AXI_tcm_rd0_wr1,
   input  logic [ADDR_W-1:0] AXI_tcm_addr,
   input  logic [3:0]        AXI_tcm_byte_strobe,
   input  logic [31:0]       AXI_tcm_write_data,
   output logic              AXI_dtcm_gnt,
   output logic [31:0]       AXI_dtcm_read_data,
   output logic              AXI_dtcm_read_data_valid,
   output logic              mem_en,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   logic                w_cpu_req;
   logic                w_axi_req;
   logic                w_cpu_win;
   logic                w_axi_win;
   logic                w_limit;
   logic [STARVE_W-1:0] w_cnt;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [ADDR_W-1:0]   w_off;
   owner_e              r_rd_owner;
   owner_e              w_rd_owner_nxt;

   assign w_cpu_req = cpu_req & ~ARESET;
   assign w_axi_req = AXI_dtcm_access & ~ARESET;

   assign w_axi_win = w_axi_req & (~w_cpu_req | w_limit);
   assign w_cpu_win = w_cpu_req & ~w_axi_win;

   assign cpu_gnt      = w_cpu_win;
   assign AXI_dtcm_gnt = w_axi_win;

   tcm_arb_starve_cnt #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .i_clk   (ACLK),
      .i_rst   (ARESET),
      .i_inc   (w_cpu_win & w_axi_req),
      .i_clr   (w_axi_win | ~AXI_dtcm_access),
      .o_limit (w_limit),
      .o_cnt   (w_cnt)
   );

   assign w_sel_addr = w_axi_win ? AXI_tcm_addr : cpu_addr;
   assign w_off      = w_sel_addr - BASE;

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_be    = 4'h0;
      mem_wdata = '0;
      if (w_cpu_win) begin
         mem_en    = 1'b1;
         mem_we    = cpu_rd0_wr1;
         mem_addr  = w_off[MEM_AW+1:2];
         mem_be    = cpu_rd0_wr1 ? cpu_byte_strobe : 4'hF;
         mem_wdata = cpu_write_data;
      end else if (w_axi_win) begin
         mem_en    = 1'b1;
         mem_we    = AXI_tcm_rd0_wr1;
         mem_addr  = w_off[MEM_AW+1:2];
         mem_be    = AXI_tcm_rd0_wr1 ? AXI_tcm_byte_strobe : 4'hF;
         mem_wdata = AXI_tcm_write_data;
      end
   end

   always_comb begin
      w_rd_owner_nxt = OWN_NONE;
      if (w_cpu_win && !cpu_rd0_wr1) begin
         w_rd_owner_nxt = OWN_CPU;
      end else if (w_axi_win && !AXI_tcm_rd0_wr1) begin
         w_rd_owner_nxt = OWN_AXI;
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_rd_owner <= OWN_NONE;
      end else begin
         r_rd_owner <= w_rd_owner_nxt;
      end
   end

   // Valids are masked in a reset cycle so a grant just before reset never returns data.
   assign cpu_read_data_valid      = (r_rd_owner == OWN_CPU) & ~ARESET;
   assign AXI_dtcm_read_data_valid = (r_rd_owner == OWN_AXI) & ~ARESET;
   assign cpu_read_data      = cpu_read_data_valid ? mem_rdata : '0;
   assign AXI_dtcm_read_data = AXI_dtcm_read_data_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_dtcm_port_arbiter.sv
// Directed bench for dtcm_port_arbiter.
// Inputs change 1ns after posedge; outputs checked 1ns later.
module tb_dtcm_port_arbiter;

   localparam int          AW   = 32;
   localparam int          MAW  = 12;
   localparam logic [31:0] BASE = 32'h2000_0000;

   logic           ACLK = 1'b0;
   logic           ARESET;
   logic           cpu_req;
   logic           cpu_rd0_wr1;
   logic [AW-1:0]  cpu_addr;
   logic [3:0]     cpu_byte_strobe;
   logic [31:0]    cpu_write_data;
   logic           cpu_gnt;
   logic [31:0]    cpu_read_data;
   logic           cpu_read_data_valid;
   logic           AXI_dtcm_access;
   logic           AXI_tcm_rd0_wr1;
   logic [AW-1:0]  AXI_tcm_addr;
   logic [3:0]     AXI_tcm_byte_strobe;
   logic [31:0]    AXI_tcm_write_data;
   logic           AXI_dtcm_gnt;
   logic [31:0]    AXI_dtcm_read_data;
   logic           AXI_dtcm_read_data_valid;
   logic           mem_en;
   logic           mem_we;
   logic [MAW-1:0] mem_addr;
   logic [3:0]     mem_be;
   logic [31:0]    mem_wdata;
   logic [31:0]    mem_rdata;

   int total = 0;
   int bad   = 0;

   always #5 ACLK = ~ACLK;

   dtcm_port_arbiter #(
      .ADDR_W       (AW),
      .DEPTH        (4096),
      .BASE         (BASE),
      .STARVE_LIMIT (4)
   ) dut (
      .ACLK                     (ACLK),
      .ARESET                   (ARESET),
      .cpu_req                  (cpu_req),
      .cpu_rd0_wr1              (cpu_rd0_wr1),
      .cpu_addr                 (cpu_addr),
      .cpu_byte_strobe          (cpu_byte_strobe),
      .cpu_write_data           (cpu_write_data),
      .cpu_gnt                  (cpu_gnt),
      .cpu_read_data            (cpu_read_data),
      .cpu_read_data_valid      (cpu_read_data_valid),
      .AXI_dtcm_access          (AXI_dtcm_access),
      .AXI_tcm_rd0_wr1          (AXI_tcm_rd0_wr1),
      .AXI_tcm_addr             (AXI_tcm_addr),
      .AXI_tcm_byte_strobe      (AXI_tcm_byte_strobe),
      .AXI_tcm_write_data       (AXI_tcm_write_data),
      .AXI_dtcm_gnt             (AXI_dtcm_gnt),
      .AXI_dtcm_read_data       (AXI_dtcm_read_data),
      .AXI_dtcm_read_data_valid (AXI_dtcm_read_data_valid),
      .mem_en                   (mem_en),
      .mem_we                   (mem_we),
      .mem_addr                 (mem_addr),
      .mem_be                   (mem_be),
      .mem_wdata                (mem_wdata),
      .mem_rdata                (mem_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   initial begin
      ARESET              = 1'b1;
      cpu_req             = 1'b1;
      cpu_rd0_wr1         = 1'b0;
      cpu_addr            = BASE + 32'h40;
      cpu_byte_strobe     = 4'h0;
      cpu_write_data      = 32'h0;
      AXI_dtcm_access     = 1'b1;
      AXI_tcm_rd0_wr1     = 1'b1;
      AXI_tcm_addr        = BASE + 32'h80;
      AXI_tcm_byte_strobe = 4'hF;
      AXI_tcm_write_data  = 32'hFFFF_FFFF;
      mem_rdata           = 32'hFFFF_FFFF;
      tick();
      tick();
      #1;
      chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
      chk("rst_axi_gnt", 32'(AXI_dtcm_gnt), 32'd0);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_cpu_vld", 32'(cpu_read_data_valid), 32'd0);
      chk("rst_cpu_rd", cpu_read_data, 32'd0);
      chk("rst_axi_rd", AXI_dtcm_read_data, 32'd0);

      // core read alone
      ARESET          = 1'b0;
      AXI_dtcm_access = 1'b0;
      cpu_req         = 1'b1;
      cpu_rd0_wr1     = 1'b0;
      cpu_addr        = BASE;
      #1;
      chk("t1_cpu_gnt", 32'(cpu_gnt), 32'd1);
      chk("t1_mem_en", 32'(mem_en), 32'd1);
      chk("t1_mem_we", 32'(mem_we), 32'd0);
      chk("t1_mem_addr", 32'(mem_addr), 32'd0);
      chk("t1_mem_be", 32'(mem_be), 32'hF);
      tick();
      cpu_req   = 1'b0;
      mem_rdata = 32'hDEAD_BEEF;
      #1;
      chk("t1_cpu_vld", 32'(cpu_read_data_valid), 32'd1);
      chk("t1_cpu_rd", cpu_read_data, 32'hDEAD_BEEF);
      chk("t1_axi_vld", 32'(AXI_dtcm_read_data_valid), 32'd0);
      chk("t1_axi_rd", AXI_dtcm_read_data, 32'd0);
      chk("t1_axi_gnt", 32'(AXI_dtcm_gnt), 32'd0);

      // AXI write
      tick();
      AXI_dtcm_access     = 1'b1;
      AXI_tcm_rd0_wr1     = 1'b1;
      AXI_tcm_addr        = BASE + 32'h10;
      AXI_tcm_byte_strobe = 4'b0011;
      AXI_tcm_write_data  = 32'h1234;
      #1;
      chk("t2_axi_gnt", 32'(AXI_dtcm_gnt), 32'd1);
      chk("t2_cpu_gnt", 32'(cpu_gnt), 32'd0);
      chk("t2_mem_we", 32'(mem_we), 32'd1);
      chk("t2_mem_addr", 32'(mem_addr), 32'd4);
      chk("t2_mem_be", 32'(mem_be), 32'b0011);
      chk("t2_mem_wdata", mem_wdata, 32'h1234);
      tick();
      AXI_dtcm_access = 1'b0;
      #1;
      chk("t2_axi_vld", 32'(AXI_dtcm_read_data_valid), 32'd0);
      chk("t2_cpu_vld", 32'(cpu_read_data_valid), 32'd0);

      // continuous contention: 4 core grants then 1 AXI
      cpu_req         = 1'b1;
      cpu_rd0_wr1     = 1'b0;
      cpu_addr        = BASE + 32'h20;
      AXI_dtcm_access = 1'b1;
      AXI_tcm_rd0_wr1 = 1'b0;
      AXI_tcm_addr    = BASE + 32'h40;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk($sformatf("t3_cpu_gnt%0d", i), 32'(cpu_gnt),
             (i % 5 == 4) ? 32'd0 : 32'd1);
         chk($sformatf("t3_axi_gnt%0d", i), 32'(AXI_dtcm_gnt),
             (i % 5 == 4) ? 32'd1 : 32'd0);
         chk($sformatf("t3_addr%0d", i), 32'(mem_addr),
             (i % 5 == 4) ? 32'd16 : 32'd8);
         tick();
      end
      cpu_req         = 1'b0;
      AXI_dtcm_access = 1'b0;
      tick();

      // core read then AXI read back to back
      cpu_req  = 1'b1;
      cpu_addr = BASE + 32'h4;
      #1;
      chk("t4_cpu_gnt", 32'(cpu_gnt), 32'd1);
      tick();
      cpu_req         = 1'b0;
      AXI_dtcm_access = 1'b1;
      AXI_tcm_addr    = BASE + 32'h8;
      mem_rdata       = 32'h1111_1111;
      #1;
      chk("t4_axi_gnt", 32'(AXI_dtcm_gnt), 32'd1);
      chk("t4_axi_addr", 32'(mem_addr), 32'd2);
      chk("t4_cpu_vld", 32'(cpu_read_data_valid), 32'd1);
      chk("t4_cpu_rd", cpu_read_data, 32'h1111_1111);
      chk("t4_axi_vld0", 32'(AXI_dtcm_read_data_valid), 32'd0);
      tick();
      AXI_dtcm_access = 1'b0;
      mem_rdata       = 32'h2222_2222;
      #1;
      chk("t4_axi_vld", 32'(AXI_dtcm_read_data_valid), 32'd1);
      chk("t4_axi_rd", AXI_dtcm_read_data, 32'h2222_2222);
      chk("t4_cpu_vld1", 32'(cpu_read_data_valid), 32'd0);
      chk("t4_cpu_rd1", cpu_read_data, 32'd0);
      tick();
      #1;
      chk("t4_axi_vld2", 32'(AXI_dtcm_read_data_valid), 32'd0);

      // reset right after an AXI read grant
      AXI_dtcm_access = 1'b1;
      #1;
      chk("t5_axi_gnt", 32'(AXI_dtcm_gnt), 32'd1);
      tick();
      AXI_dtcm_access = 1'b0;
      ARESET          = 1'b1;
      #1;
      chk("t5_axi_vld", 32'(AXI_dtcm_read_data_valid), 32'd0);
      chk("t5_axi_rd", AXI_dtcm_read_data, 32'd0);
      chk("t5_mem_en", 32'(mem_en), 32'd0);
      tick();
      ARESET = 1'b0;
      #1;
      chk("t5_axi_vld2", 32'(AXI_dtcm_read_data_valid), 32'd0);
      chk("t5_cpu_vld2", 32'(cpu_read_data_valid), 32'd0);

      // AXI drops after 3 losses, counter restarts
      cpu_req         = 1'b1;
      AXI_dtcm_access = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("t6_lose%0d", i), 32'(AXI_dtcm_gnt), 32'd0);
         tick();
      end
      AXI_dtcm_access = 1'b0;
      #1;
      chk("t6_cpu_alone", 32'(cpu_gnt), 32'd1);
      tick();
      AXI_dtcm_access = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("t6_cpu%0d", i), 32'(cpu_gnt),
             (i == 4) ? 32'd0 : 32'd1);
         chk($sformatf("t6_axi%0d", i), 32'(AXI_dtcm_gnt),
             (i == 4) ? 32'd1 : 32'd0);
         tick();
      end
      cpu_req         = 1'b0;
      AXI_dtcm_access = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
